dmem_responder: RTL and testbench

Memory-side responder for the pipelined processor's data-memory port. It accepts one load/store request at a time over a req/ready handshake and serves it from an internal word array after a fixed, parameterised number of wait states. The processor holds its request stable and stalls until `ready` pulses. The block replaces the zero-latency data memory so the pipeline's stall path is exercised against a realistic multi-cycle memory.

---
 rtl/dmem_responder.sv | 112 +++++++++++
 tb/tb_dmem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: serves one load/store per req/ready
// handshake from an internal word array after LATENCY wait states.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [DEPTH_LOG2+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_ready;
  logic                  r_err;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_capture;
  logic                  w_access;
  logic                  w_misaligned;
  logic                  w_store;
  logic [DEPTH_LOG2-1:0] w_index;
  logic                  w_unused_addr;

  // Upper address bits are deliberately dropped so accesses wrap around the array.
  assign w_unused_addr = ^addr[31:DEPTH_LOG2+2];

  assign w_index      = r_addr[DEPTH_LOG2+1:2];
  assign w_misaligned = (r_addr[1:0] != 2'b00);
  assign w_capture    = (r_state == S_IDLE) && req;
  assign w_access     = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_store      = w_access && r_we && !w_misaligned;

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (req) w_next_state = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next_state;

      if (w_capture) begin
        r_we    <= we;
        r_addr  <= addr[DEPTH_LOG2+1:0];
        r_wdata <= wdata;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_access) begin
        r_ready <= 1'b1;
        r_err   <= w_misaligned;
        r_rdata <= (w_misaligned || r_we) ? 32'd0 : r_mem[w_index];
      end else if (r_state == S_RESP) begin
        // rdata intentionally holds its last value after the response cycle.
        r_ready <= 1'b0;
        r_err   <= 1'b0;
      end
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM and keeps its contents across rst_n.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[w_index] <= r_wdata;
    end
  end

  assign ready = r_ready;
  assign rdata = r_rdata;
  assign err   = r_err;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 1, 2, 15)
// share stimulus; a reference model predicts data, err and ready timing.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int NI    = 3;
  localparam int WORDS = 64;

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        err;
    int          rcyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req;
  logic          we;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  int            sel;
  logic [NI-1:0] req_v;
  logic [NI-1:0] ready_v;
  logic [NI-1:0] err_v;
  logic [NI-1:0] busy_v;
  logic [31:0]   rdata_v [NI];

  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  exp_t          q [$];
  logic [31:0]   mem_m [NI][WORDS];
  int            free_c [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_v = '0;
    for (int k = 0; k < NI; k++) req_v[k] = req && (sel == k);
  end

  dmem_responder #(.DEPTH_LOG2(6), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready_v[0]), .rdata(rdata_v[0]), .err(err_v[0]), .busy(busy_v[0]));
  dmem_responder #(.DEPTH_LOG2(6), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready_v[1]), .rdata(rdata_v[1]), .err(err_v[1]), .busy(busy_v[1]));
  dmem_responder #(.DEPTH_LOG2(6), .LATENCY(15)) u_dut_l15 (
    .clk(clk), .rst_n(rst_n), .req(req_v[2]), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready_v[2]), .rdata(rdata_v[2]), .err(err_v[2]), .busy(busy_v[2]));

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 15;
  endfunction

  function automatic int word_of(logic [31:0] a);
    return int'((a >> 2) % WORDS);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one access to instance k and wait for its ready pulse.
  task automatic access(int k, logic w, logic [31:0] a, logic [31:0] d, bit hold, bit scramble);
    int   cap;
    bit   seen;
    exp_t e;
    @(negedge clk);
    sel = k; req = 1'b1; we = w; addr = a; wdata = d;
    cap = (cyc + 1 > free_c[k]) ? cyc + 1 : free_c[k];
    free_c[k] = cap + lat_of(k) + 2;
    e.k    = k;
    e.rcyc = cap + lat_of(k);
    if (a[1:0] != 2'b00) begin
      e.err = 1'b1; e.rdata = 32'd0;
    end else if (w) begin
      e.err = 1'b0; e.rdata = 32'd0;
      mem_m[k][word_of(a)] = d;
    end else begin
      e.err = 1'b0; e.rdata = mem_m[k][word_of(a)];
    end
    q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (ready_v[k]) seen = 1'b1;
      else if (scramble && cyc >= cap) begin
        addr  = $urandom;
        wdata = $urandom;
      end
    end
    if (!seen) check("ready_timeout", 32'd0, 32'd1);
    if (!hold) req = 1'b0;
  endtask

  // Pre-store 0x22222222 at 0x30, start a store of 0x11111111 and reset during WAIT.
  task automatic reset_mid(int k);
    int cap;
    access(k, 1'b1, 32'h30, 32'h2222_2222, 1'b0, 1'b0);
    @(negedge clk);
    sel = k; req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h1111_1111;
    cap = (cyc + 1 > free_c[k]) ? cyc + 1 : free_c[k];
    for (int i = 0; i < 40 && cyc < cap; i++) @(negedge clk);
    check("busy_in_wait", {31'd0, busy_v[k]}, 32'd1);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("busy_during_reset", {31'd0, busy_v[k]}, 32'd0);
    check("ready_during_reset", {31'd0, ready_v[k]}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < NI; j++) free_c[j] = 0;
    access(k, 1'b0, 32'h30, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (ready_v[k]) begin
          if (q.size() == 0) begin
            check("ready_without_request", {31'd0, ready_v[k]}, 32'd0);
          end else begin
            e = q.pop_front();
            check("ready_instance", k, e.k);
            check("rdata", rdata_v[k], e.rdata);
            check("err", {31'd0, err_v[k]}, {31'd0, e.err});
            check("ready_cycle", cyc, e.rcyc);
            check("busy_in_resp", {31'd0, busy_v[k]}, 32'd1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic        w;
    logic [31:0] a;
    bit          hold;
    sel = 0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    for (int k = 0; k < NI; k++) free_c[k] = 0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("reset_ready", {31'd0, ready_v[k]}, 32'd0);
      check("reset_err", {31'd0, err_v[k]}, 32'd0);
      check("reset_rdata", rdata_v[k], 32'd0);
      check("reset_busy", {31'd0, busy_v[k]}, 32'd0);
    end
    repeat (10) @(negedge clk);

    for (int k = 0; k < NI; k++)
      for (int i = 0; i < WORDS; i++)
        access(k, 1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);

    access(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    access(1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0);
    access(1, 1'b1, 32'h20, 32'h0000_A5A5, 1'b0, 1'b0);
    access(1, 1'b1, 32'h21, 32'h1234_5678, 1'b0, 1'b0);
    access(1, 1'b0, 32'h20, 32'd0, 1'b0, 1'b0);
    access(1, 1'b1, 32'h104, 32'hCAFE_F00D, 1'b0, 1'b0);
    access(1, 1'b0, 32'h4, 32'd0, 1'b0, 1'b0);
    access(1, 1'b0, 32'h0, 32'd0, 1'b1, 1'b0);
    access(1, 1'b0, 32'h4, 32'd0, 1'b1, 1'b1);
    access(1, 1'b0, 32'h8, 32'd0, 1'b0, 1'b1);

    for (int k = 0; k < NI; k++) reset_mid(k);

    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom % 2);
      a = $urandom;
      if ($urandom % 4 != 0) a[1:0] = 2'b00;
      hold = (i < 299) ? bit'($urandom % 2) : 1'b0;
      access(int'($urandom % NI), w, a, $urandom, hold, bit'($urandom % 2));
    end

    repeat (5) @(negedge clk);
    check("pending_responses", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
